// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware channel FIFO with fill level and end-of-packet pulse.
// Define ROUTER_FIFO_PARITY_CHK_EN to build the per-packet parity checker.
module router_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic                     parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-2:0] CNT_ONE = 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-2:0] pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pkt_done_q, pkt_done_d;
  logic              wr, rd, rd_lfd, last;
  logic [DATA_W-1:0] rd_data;

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = wptr_q == rptr_q;
  assign count    = wptr_q - rptr_q;
  assign wr       = write_enb && !full;
  assign rd       = read_enb && !empty;
  assign {rd_lfd, rd_data} = mem[rptr_q[AW-1:0]];
  // parity byte is the payload byte that takes the counter from 1 to 0
  assign last     = rd && !rd_lfd && pkt_cnt_q == CNT_ONE;
  assign data_out = data_out_q;
  assign pkt_done = pkt_done_q;

  always_comb begin
    wptr_d     = soft_reset ? '0 : wptr_q + {{AW{1'b0}}, wr};
    rptr_d     = soft_reset ? '0 : rptr_q + {{AW{1'b0}}, rd};
    data_out_d = soft_reset ? '0 : rd ? rd_data : data_out_q;
    pkt_cnt_d  = soft_reset ? '0 : !rd ? pkt_cnt_q :
                 rd_lfd ? {1'b0, rd_data[DATA_W-1:2]} + CNT_ONE :
                 pkt_cnt_q != '0 ? pkt_cnt_q - CNT_ONE : pkt_cnt_q;
    pkt_done_d = !soft_reset && last;
  end

  always_ff @(posedge clk)
    if (wr && !soft_reset) mem[wptr_q[AW-1:0]] <= {lfd_state, data_in};

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
      pkt_done_q <= pkt_done_d;
    end

`ifdef ROUTER_FIFO_PARITY_CHK_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              parity_err_q, parity_err_d;

  always_comb begin
    acc_d        = soft_reset ? '0 : !rd ? acc_q : rd_lfd ? rd_data :
                   pkt_cnt_q > CNT_ONE ? acc_q ^ rd_data : acc_q;
    parity_err_d = !soft_reset && last && acc_q != rd_data;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      acc_q        <= '0;
      parity_err_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      parity_err_q <= parity_err_d;
    end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed vectors, corner sequences and a queue-based model for router_pkt_fifo.
module tb_router_pkt_fifo;
  logic       clk = 0, resetn = 1, soft_reset = 0, write_enb = 0, lfd_state = 0, read_enb = 0;
  logic [7:0] data_in = 0, data_out;
  logic       empty, full, pkt_done, parity_err;
  logic [4:0] count;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .empty(empty), .full(full), .count(count), .pkt_done(pkt_done), .parity_err(parity_err)
  );

  typedef struct {
    bit we, lfd, re, sr;
    logic [7:0] din, dout;
    int cnt;
    bit done;
  } vec_t;
  vec_t vecs[$];

  logic [8:0] mq[$];
  int         m_pc;
  logic [7:0] m_dout, m_acc;
  bit         m_done, m_perr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit we, bit lfd, logic [7:0] din, bit re, bit sr);
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; soft_reset = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic v(bit we, bit lfd, logic [7:0] din, bit re, bit sr, logic [7:0] dout, int cnt, bit done);
    vecs.push_back('{we, lfd, re, sr, din, dout, cnt, done});
  endtask

  initial begin
    #1 resetn = 0;
    #2;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0); chk("rst_done", pkt_done, 0);
    tick(); tick();
    resetn = 1;

    // packet pass-through: header 0C (len 3), payload, parity 0C
    v(1,1,8'h0C,0,0, 8'h00,1,0); v(1,0,8'h11,0,0, 8'h00,2,0); v(1,0,8'h22,0,0, 8'h00,3,0);
    v(1,0,8'h33,0,0, 8'h00,4,0); v(1,0,8'h0C,0,0, 8'h00,5,0);
    v(0,0,8'h00,1,0, 8'h0C,4,0); v(0,0,8'h00,1,0, 8'h11,3,0); v(0,0,8'h00,1,0, 8'h22,2,0);
    v(0,0,8'h00,1,0, 8'h33,1,0); v(0,0,8'h00,1,0, 8'h0C,0,1);
    v(0,0,8'h00,0,0, 8'h0C,0,0); v(0,0,8'h00,1,0, 8'h0C,0,0);
    // simultaneous read+write at count 5
    v(1,0,8'hA1,0,0, 8'h0C,1,0); v(1,0,8'hA2,0,0, 8'h0C,2,0); v(1,0,8'hA3,0,0, 8'h0C,3,0);
    v(1,0,8'hA4,0,0, 8'h0C,4,0); v(1,0,8'hA5,0,0, 8'h0C,5,0);
    v(1,0,8'hB1,1,0, 8'hA1,5,0); v(0,0,8'h00,1,0, 8'hA2,4,0); v(0,0,8'h00,1,0, 8'hA3,3,0);
    v(0,0,8'h00,1,0, 8'hA4,2,0); v(0,0,8'h00,1,0, 8'hA5,1,0); v(0,0,8'h00,1,0, 8'hB1,0,0);
    // soft reset mid-packet (header len 10), then a zero-length packet
    v(1,1,8'h28,0,0, 8'hB1,1,0); v(1,0,8'h01,0,0, 8'hB1,2,0); v(1,0,8'h02,0,0, 8'hB1,3,0);
    v(1,0,8'h03,0,0, 8'hB1,4,0); v(1,0,8'h04,0,0, 8'hB1,5,0);
    v(0,0,8'h00,1,0, 8'h28,4,0); v(0,0,8'h00,1,0, 8'h01,3,0); v(0,0,8'h00,1,0, 8'h02,2,0);
    v(1,0,8'h55,1,1, 8'h00,0,0);
    v(1,1,8'h01,0,0, 8'h00,1,0); v(1,0,8'h01,0,0, 8'h00,2,0);
    v(0,0,8'h00,1,0, 8'h01,1,0); v(0,0,8'h00,1,0, 8'h01,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].lfd, vecs[i].din, vecs[i].re, vecs[i].sr);
      tick();
      chk($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_done", i), pkt_done, vecs[i].done);
      chk($sformatf("vec%0d_perr", i), parity_err, 0);
    end

    // full / drop / wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin drive(1, 0, 8'(r*16+i), 0, 0); tick(); end
      chk("wrap_full", full, 1); chk("wrap_count", count, 16);
      drive(1, 0, 8'hFF, 0, 0); tick();
      chk("drop_count", count, 16); chk("drop_full", full, 1);
      for (int i = 0; i < 16; i++) begin
        drive(0, 0, 0, 1, 0); tick();
        chk("wrap_data", data_out, 8'(r*16+i));
      end
      chk("wrap_empty", empty, 1); chk("wrap_count0", count, 0);
    end

    // read+write while full: write dropped
    for (int i = 0; i < 16; i++) begin drive(1, 0, 8'(8'h40+i), 0, 0); tick(); end
    drive(1, 0, 8'hEE, 1, 0); tick();
    chk("fullrw_dout", data_out, 8'h40); chk("fullrw_count", count, 15); chk("fullrw_full", full, 0);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 1, 0); tick();
      chk("fullrw_data", data_out, 8'(8'h40+i));
    end
    chk("fullrw_empty", empty, 1);
    drive(0, 0, 0, 0, 0); tick();

`ifdef ROUTER_FIFO_PARITY_CHK_EN
    drive(1, 1, 8'h0C, 0, 0); tick();
    drive(1, 0, 8'h11, 0, 0); tick();
    drive(1, 0, 8'h22, 0, 0); tick();
    drive(1, 0, 8'h33, 0, 0); tick();
    drive(1, 0, 8'h0D, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0); tick();
      chk("perr_early", parity_err, 0);
    end
    drive(0, 0, 0, 1, 0); tick();
    chk("perr_pulse", parity_err, 1); chk("perr_done", pkt_done, 1);
    drive(0, 0, 0, 0, 0); tick();
    chk("perr_clear", parity_err, 0); chk("perr_done_clear", pkt_done, 0);
`endif

    // randomized traffic against a queue model
    drive(0, 0, 0, 0, 1); tick();
    mq.delete(); m_pc = 0; m_dout = 0; m_acc = 0; m_done = 0; m_perr = 0;
    for (int c = 0; c < 3000; c++) begin
      bit we, re, lfd, sr, wr_ok, rd_ok;
      logic [7:0] din;
      logic [8:0] e;
      we  = $urandom_range(0, 99) < 55;
      re  = $urandom_range(0, 99) < 50;
      sr  = $urandom_range(0, 199) == 0;
      lfd = $urandom_range(0, 4) == 0;
      din = lfd ? 8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      drive(we, lfd, din, re, sr);
      if (sr) begin
        mq.delete(); m_pc = 0; m_dout = 0; m_acc = 0; m_done = 0; m_perr = 0;
      end else begin
        wr_ok = we && mq.size() < 16;
        rd_ok = re && mq.size() > 0;
        m_done = 0; m_perr = 0;
        if (rd_ok) begin
          e = mq.pop_front();
          m_dout = e[7:0];
          if (e[8]) begin
            m_pc = int'(e[7:2]) + 1; m_acc = e[7:0];
          end else if (m_pc == 1) begin
            m_done = 1;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
            m_perr = m_acc != e[7:0];
`endif
            m_pc = 0;
          end else if (m_pc > 1) begin
            m_acc ^= e[7:0]; m_pc--;
          end
        end
        if (wr_ok) mq.push_back({lfd, din});
      end
      tick();
      chk("rnd_dout", data_out, m_dout); chk("rnd_count", count, mq.size());
      chk("rnd_empty", empty, mq.size() == 0); chk("rnd_full", full, mq.size() == 16);
      chk("rnd_done", pkt_done, m_done); chk("rnd_perr", parity_err, m_perr);
      if (c == 1500) begin
        #2 resetn = 0;
        #1;
        chk("arst_empty", empty, 1); chk("arst_full", full, 0); chk("arst_count", count, 0);
        chk("arst_dout", data_out, 0); chk("arst_done", pkt_done, 0);
        tick();
        resetn = 1;
        mq.delete(); m_pc = 0; m_dout = 0; m_acc = 0; m_done = 0; m_perr = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised packet-aware FIFO for the 1x3 router; one instance per output channel, between the router's synchroniser/FSM (write side) and the output port (read side). Stores each byte with its first-byte (lfd) marker, tracks packet length from the header so the read side knows when a packet ends, and exposes fill level. Generalises the fixed 16x9 channel FIFO to arbitrary data width and power-of-two depth, adding occupancy count, end-of-packet signalling and optional parity checking.

## Interface
- DATA_W, 8, data byte width (>= 3); header length field is data_in[DATA_W-1:2]
- DEPTH, 16, number of entries; power of two, >= 4
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  input  1  single clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- soft_reset  input  1  synchronous flush (channel timeout from router FSM), active-high
- write_enb  input  1  write request
- lfd_state  input  1  marks data_in as packet header (first byte)
- data_in  input  DATA_W  write data
- read_enb  input  1  read request
- data_out  output  DATA_W  registered read data
- empty  output  1  no entries stored
- full  output  1  DEPTH entries stored
- count  output  AW+1  entries stored, 0..DEPTH
- pkt_done  output  1  one-cycle pulse: last byte (parity) of a packet presented on data_out
- parity_err  output  1  one-cycle pulse with pkt_done on parity mismatch (only with macro; else tied 0)

## Operation
- Storage: DEPTH x (DATA_W+1) array, entry = {lfd_state, data_in}. Write/read pointers AW+1 bits; wrap naturally modulo 2*DEPTH.
- full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]); empty = (wptr == rptr); count = wptr - rptr. All combinational from pointers.
- Write accepted iff write_enb && !full; read accepted iff read_enb && !empty. Both may occur in one cycle; count unchanged. Write while full is dropped (no pointer move, no corruption); read while empty is ignored, data_out holds.
- Packet counter pkt_cnt (DATA_W-1 bits): on accepted read of an entry with lfd=1, pkt_cnt <= header[DATA_W-1:2] + 1 (payload + parity). On accepted read of lfd=0 entry with pkt_cnt != 0, pkt_cnt decrements. When that decrement goes 1 -> 0, pkt_done pulses in the same cycle data_out shows that byte.
- Header with length 0: pkt_cnt = 1; next byte read is parity, pkt_done pulses on it.
- New header read while pkt_cnt != 0 (truncated packet): counter reloads from new header; no pkt_done for the truncated packet.
- Reads of lfd=0 entries with pkt_cnt == 0 are delivered but do not pulse pkt_done.

## Timing
- Read latency 1 cycle: data_out updates on the clock edge that accepts the read.
- Write-to-read: entry written at edge N is readable (empty low) after edge N; earliest data_out at edge N+1.
- flags/count reflect pointer state immediately after each edge; no extra pipeline.
- resetn low (any time, async): pointers, pkt_cnt, parity accumulator, data_out, pkt_done, parity_err all 0; empty=1, full=0, count=0. Memory contents not cleared.
- soft_reset high at edge: same values as reset, synchronously; takes priority over simultaneous read/write in that cycle.
- Reset or soft_reset mid-packet discards the partial packet; no pkt_done issued.

## Configuration
- ROUTER_FIFO_PARITY_CHK_EN defined: running XOR accumulator loaded with header on header read, XORed with each payload byte read; on the parity byte read (pkt_cnt 1 -> 0), parity_err pulses with pkt_done if accumulator != parity byte. Cleared by reset/soft_reset.
- Not defined: accumulator not built; parity_err constant 0.

## Test plan
- Reset: resetn low mid-traffic -> empty=1, full=0, count=0, data_out=0 without waiting for clk.
- Packet pass-through (DATA_W=8, DEPTH=16): write header 8'h0C (len 3), payload 11,22,33, parity 8'h0C^11^22^33; read 5 -> data_out sequence matches, pkt_done pulses only on 5th read, parity_err=0.
- Full/wrap: write 16 -> full=1, count=16; 17th write dropped; read 16 -> values intact, empty=1; repeat 3 times across pointer wrap.
- Simultaneous: at count=16 assert read+write -> write dropped, count=15; at count=5 assert both -> count stays 5, order preserved.
- Soft reset mid-packet: header len 10, read 3 bytes, pulse soft_reset -> count=0, data_out=0, no pkt_done; next packet len 0 pulses pkt_done on its 2nd byte.
- Parity error (macro defined): corrupt parity byte by 8'h01 -> parity_err and pkt_done pulse together for one cycle.
